// File: rtl/lsu.sv
// -----------------------------------------------------------------------------
// lsu - load/store unit for the nano_rv32i core
//
// Responder side of the decoder's load/store handshake. A request is taken in
// IDLE when ls_i=1. A legal request runs one req/ack transaction on the
// word-wide data-memory port. An illegal request (bad type, bad funct3 or a
// misaligned address) skips memory and finishes with err_o. Every output is
// registered.
//
// Handshake: in IDLE, ls_i=1 accepts the request on that rising edge. All
// request inputs are sampled only on that edge. mem_req_o then stays high,
// with addr/we/be/wdata stable, until an edge where mem_ack_i=1 completes
// the access. done_o pulses for one cycle after that edge, together with
// load_ready_o (successful load) or err_o (illegal request).
//
// Ports:
//   clk_i, rst_i          clock (rising edge), async active-high reset
//   ls_i                  request strobe from the decoder
//   mem_read_i/_write_i   request type (exactly one must be set)
//   funct3_i              RV32I load/store size/sign
//   addr_i, wdata_i       effective byte address, store data (rs2)
//   load_ready_o          1-cycle pulse: rdata_o holds a fresh load result
//   done_o, err_o         1-cycle pulse: request finished / was illegal
//   rdata_o               formatted load result, held until the next load
//   mem_req_o, mem_we_o   memory request (held until ack), write enable
//   mem_addr_o            word address {addr[31:2],2'b00}
//   mem_be_o, mem_wdata_o byte enables, lane-replicated store data
//   mem_ack_i, mem_rdata_i memory completion and read word
// -----------------------------------------------------------------------------
module lsu (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        ls_i,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [31:0] addr_i,
   input  logic [31:0] wdata_i,
   output logic        load_ready_o,
   output logic        done_o,
   output logic        err_o,
   output logic [31:0] rdata_o,
   output logic        mem_req_o,
   output logic        mem_we_o,
   output logic [31:0] mem_addr_o,
   output logic [3:0]  mem_be_o,
   output logic [31:0] mem_wdata_o,
   input  logic        mem_ack_i,
   input  logic [31:0] mem_rdata_i
);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]  r_state;
   logic        r_is_load;
   logic [2:0]  r_funct3;
   logic [1:0]  r_off;

   logic        w_illegal;
   logic [3:0]  w_be;
   logic [31:0] w_wdata;
   logic [7:0]  w_byte;
   logic [15:0] w_half;
   logic [31:0] w_load;

   // Legality check on the live request inputs. funct3[1:0] gives the
   // access size for loads and stores alike.
   always_comb begin
      w_illegal = 1'b0;
      if (mem_read_i == mem_write_i) begin
         w_illegal = 1'b1;
      end else if (mem_read_i) begin
         case (funct3_i)
            3'b011, 3'b110, 3'b111: w_illegal = 1'b1;
            default:                w_illegal = 1'b0;
         endcase
      end else if (funct3_i[2] || (funct3_i[1:0] == 2'b11)) begin
         w_illegal = 1'b1;
      end
      case (funct3_i[1:0])
         2'b01:   if (addr_i[0])            w_illegal = 1'b1;
         2'b10:   if (addr_i[1:0] != 2'b00) w_illegal = 1'b1;
         default: ;
      endcase
   end

   // Byte enables and replicated store data. Loads get the same enables.
   always_comb begin
      case (funct3_i[1:0])
         2'b00: begin
            w_be    = 4'b0001 << addr_i[1:0];
            w_wdata = {4{wdata_i[7:0]}};
         end
         2'b01: begin
            w_be    = 4'b0011 << {addr_i[1], 1'b0};
            w_wdata = {2{wdata_i[15:0]}};
         end
         default: begin
            w_be    = 4'b1111;
            w_wdata = wdata_i;
         end
      endcase
   end

   // Load formatting uses the captured byte offset. mem_addr_o has the low
   // bits cleared, so it cannot supply the offset.
   always_comb begin
      case (r_off)
         2'd0:    w_byte = mem_rdata_i[7:0];
         2'd1:    w_byte = mem_rdata_i[15:8];
         2'd2:    w_byte = mem_rdata_i[23:16];
         default: w_byte = mem_rdata_i[31:24];
      endcase
      w_half = r_off[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
      case (r_funct3)
         3'b000:  w_load = {{24{w_byte[7]}}, w_byte};
         3'b100:  w_load = {24'd0, w_byte};
         3'b001:  w_load = {{16{w_half[15]}}, w_half};
         3'b101:  w_load = {16'd0, w_half};
         default: w_load = mem_rdata_i;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state      <= S_IDLE;
         r_is_load    <= 1'b0;
         r_funct3     <= 3'd0;
         r_off        <= 2'd0;
         load_ready_o <= 1'b0;
         done_o       <= 1'b0;
         err_o        <= 1'b0;
         rdata_o      <= 32'd0;
         mem_req_o    <= 1'b0;
         mem_we_o     <= 1'b0;
         mem_addr_o   <= 32'd0;
         mem_be_o     <= 4'd0;
         mem_wdata_o  <= 32'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (ls_i) begin
                  r_is_load <= mem_read_i;
                  r_funct3  <= funct3_i;
                  r_off     <= addr_i[1:0];
                  if (w_illegal) begin
                     // No memory transaction: finish straight away.
                     done_o  <= 1'b1;
                     err_o   <= 1'b1;
                     r_state <= S_DONE;
                  end else begin
                     mem_req_o   <= 1'b1;
                     mem_we_o    <= mem_write_i;
                     mem_addr_o  <= {addr_i[31:2], 2'b00};
                     mem_be_o    <= w_be;
                     mem_wdata_o <= w_wdata;
                     r_state     <= S_REQ;
                  end
               end
            end
            S_REQ: begin
               if (mem_ack_i) begin
                  mem_req_o    <= 1'b0;
                  done_o       <= 1'b1;
                  load_ready_o <= r_is_load;
                  if (r_is_load) begin
                     rdata_o <= w_load;
                  end
                  r_state <= S_DONE;
               end
            end
            S_DONE: begin
               done_o       <= 1'b0;
               err_o        <= 1'b0;
               load_ready_o <= 1'b0;
               r_state      <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_lsu.sv
// -----------------------------------------------------------------------------
// tb_lsu - self-checking bench for lsu
//
// A driver task issues one request at a time. It plays the memory side with a
// chosen ack delay. It also sets the expected output values for each cycle,
// taken from the request/ack timeline and from model functions for legality,
// lanes and load formatting. One compare process checks the outputs at every
// falling edge. Literal checks after the directed cases pin the model.
// -----------------------------------------------------------------------------
module tb_lsu;

   logic        clk = 1'b0;
   logic        rst;
   logic        ls;
   logic        mem_read;
   logic        mem_write;
   logic [2:0]  funct3;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic        load_ready;
   logic        done;
   logic        err;
   logic [31:0] rdata;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [3:0]  mem_be;
   logic [31:0] mem_wdata;
   logic        mem_ack;
   logic [31:0] mem_rdata;

   lsu dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .ls_i         (ls),
      .mem_read_i   (mem_read),
      .mem_write_i  (mem_write),
      .funct3_i     (funct3),
      .addr_i       (addr),
      .wdata_i      (wdata),
      .load_ready_o (load_ready),
      .done_o       (done),
      .err_o        (err),
      .rdata_o      (rdata),
      .mem_req_o    (mem_req),
      .mem_we_o     (mem_we),
      .mem_addr_o   (mem_addr),
      .mem_be_o     (mem_be),
      .mem_wdata_o  (mem_wdata),
      .mem_ack_i    (mem_ack),
      .mem_rdata_i  (mem_rdata)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- bookkeeping ----------------
   int n_cmp = 0;
   int n_err = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   function automatic int unsigned m_size(input logic [2:0] f);
      return 1 << f[1:0];
   endfunction

   function automatic logic m_legal(input logic r, input logic w,
                                    input logic [2:0] f, input logic [31:0] a);
      if (r == w) return 1'b0;
      if (r && (f == 3'd3 || f == 3'd6 || f == 3'd7)) return 1'b0;
      if (w && f > 3'd2) return 1'b0;
      if ((a % m_size(f)) != 0) return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [3:0] m_be(input logic [2:0] f, input logic [31:0] a);
      int unsigned sz;
      int unsigned mask;
      sz = m_size(f);
      mask = ((1 << sz) - 1) << (a % 4);
      return mask[3:0];
   endfunction

   function automatic logic [31:0] m_wdata(input logic [2:0] f, input logic [31:0] d);
      case (m_size(f))
         1:       return d[7:0] * 32'h0101_0101;
         2:       return d[15:0] * 32'h0001_0001;
         default: return d;
      endcase
   endfunction

   function automatic logic [31:0] m_load(input logic [2:0] f, input logic [31:0] a,
                                          input logic [31:0] word);
      int unsigned sz;
      logic [31:0] v;
      logic [31:0] mask;
      sz = m_size(f);
      if (sz == 4) return word;
      v    = word >> (8 * (a % 4));
      mask = (sz == 1) ? 32'h0000_00FF : 32'h0000_FFFF;
      v    = v & mask;
      if (!f[2] && v[8*sz-1]) v = v | ~mask;
      return v;
   endfunction

   // ---------------- expected outputs for the current cycle ----------------
   logic        chk_en = 1'b0;
   logic        exp_req, exp_we, exp_done, exp_err, exp_lr;
   logic [31:0] exp_addr, exp_wdata, exp_rdata;
   logic [3:0]  exp_be;
   // Last values seen on the memory port while mem_req_o was high.
   logic [31:0] cap_addr, cap_wdata;
   logic [3:0]  cap_be;
   logic        cap_we;
   int          n_done = 0;

   always @(negedge clk) begin
      if (chk_en) begin
         check("mem_req", mem_req, exp_req);
         check("done", done, exp_done);
         check("err", err, exp_err);
         check("load_ready", load_ready, exp_lr);
         check("rdata", rdata, exp_rdata);
         if (exp_req) begin
            check("mem_addr", mem_addr, exp_addr);
            check("mem_be", mem_be, exp_be);
            check("mem_we", mem_we, exp_we);
            if (exp_we) check("mem_wdata", mem_wdata, exp_wdata);
         end
      end
      if (mem_req) begin
         cap_addr  = mem_addr;
         cap_be    = mem_be;
         cap_we    = mem_we;
         cap_wdata = mem_wdata;
      end
      if (done) n_done++;
   end

   task automatic clear_exp();
      exp_req = 0; exp_we = 0; exp_done = 0; exp_err = 0; exp_lr = 0;
      exp_addr = 0; exp_wdata = 0; exp_be = 0;
   endtask

   // ---------------- driver ----------------
   // Called #1 after a rising edge with the DUT idle. Returns #1 after the
   // rising edge that ends the DONE cycle, i.e. in the next IDLE cycle.
   task automatic run_req(input logic r, input logic w, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] d,
                          input int delay, input logic [31:0] word, input logic tie);
      logic legal;
      legal = m_legal(r, w, f, a);
      ls = 1; mem_read = r; mem_write = w; funct3 = f; addr = a; wdata = d;
      mem_ack   = tie ? 1'b1 : 1'($urandom_range(0, 1));
      mem_rdata = $urandom;
      @(posedge clk); #1;
      // Cycle 1: inputs are now don't-care.
      ls = 0; mem_read = 1'($urandom); mem_write = 1'($urandom);
      funct3 = 3'($urandom); addr = $urandom; wdata = $urandom;
      if (!legal) begin
         exp_done = 1; exp_err = 1;
         if (!tie) mem_ack = 1'($urandom_range(0, 1));
         @(posedge clk); #1;
         exp_done = 0; exp_err = 0;
      end else begin
         exp_req   = 1;
         exp_we    = w;
         exp_addr  = {a[31:2], 2'b00};
         exp_be    = m_be(f, a);
         exp_wdata = m_wdata(f, d);
         for (int i = 0; i < delay && !tie; i++) begin
            mem_ack = 0; mem_rdata = $urandom;
            @(posedge clk); #1;
         end
         mem_ack = 1; mem_rdata = word;
         @(posedge clk); #1;
         exp_req  = 0;
         exp_done = 1;
         exp_lr   = r;
         if (r) exp_rdata = m_load(f, a, word);
         if (!tie) mem_ack = 1'($urandom_range(0, 1));
         mem_rdata = $urandom;
         @(posedge clk); #1;
         exp_done = 0; exp_lr = 0;
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int done_before;
      logic        r, w;
      logic [2:0]  f;
      logic [31:0] a;
      int          op;

      rst = 1; ls = 0; mem_read = 0; mem_write = 0; funct3 = 0; addr = 0; wdata = 0;
      mem_ack = 0; mem_rdata = 0;
      clear_exp(); exp_rdata = 0;
      #12;
      check("rst_mem_req", mem_req, 0);
      check("rst_done", done, 0);
      check("rst_err", err, 0);
      check("rst_load_ready", load_ready, 0);
      check("rst_rdata", rdata, 0);
      check("rst_mem_addr", mem_addr, 0);
      check("rst_mem_be", mem_be, 0);
      check("rst_mem_wdata", mem_wdata, 0);
      check("rst_mem_we", mem_we, 0);
      @(posedge clk); #1;
      rst = 0;
      @(posedge clk); #1;
      chk_en = 1;

      // LW, ack after 3 wait cycles.
      run_req(1, 0, 3'b010, 32'h104, 0, 3, 32'hDEAD_BEEF, 0);
      check("lw_rdata_lit", rdata, 32'hDEAD_BEEF);
      check("lw_addr_lit", cap_addr, 32'h104);
      check("lw_be_lit", cap_be, 4'b1111);
      check("lw_we_lit", cap_we, 0);

      // Byte/half loads with sign and zero extension.
      run_req(1, 0, 3'b000, 32'h103, 0, 1, 32'h80FF_7F01, 0);
      check("lb_lit", rdata, 32'hFFFF_FF80);
      run_req(1, 0, 3'b100, 32'h103, 0, 0, 32'h80FF_7F01, 0);
      check("lbu_lit", rdata, 32'h0000_0080);
      run_req(1, 0, 3'b001, 32'h102, 0, 2, 32'h80FF_7F01, 0);
      check("lh_lit", rdata, 32'hFFFF_80FF);
      run_req(1, 0, 3'b101, 32'h102, 0, 0, 32'h80FF_7F01, 0);
      check("lhu_lit", rdata, 32'h0000_80FF);

      // Stores.
      run_req(0, 1, 3'b000, 32'h201, 32'h1234_56AB, 1, 0, 0);
      check("sb_be_lit", cap_be, 4'b0010);
      check("sb_wdata_lit", cap_wdata, 32'hABAB_ABAB);
      check("sb_we_lit", cap_we, 1);
      check("sb_rdata_kept", rdata, 32'h0000_80FF);
      run_req(0, 1, 3'b001, 32'h202, 32'h1234_56AB, 0, 0, 0);
      check("sh_be_lit", cap_be, 4'b1100);
      check("sh_wdata_lit", cap_wdata, 32'h56AB_56AB);

      // Misaligned requests: no memory access, error pulse.
      cap_addr = 32'hFFFF_FFFF;
      run_req(1, 0, 3'b010, 32'h102, 0, 0, 32'h1111_1111, 0);
      run_req(0, 1, 3'b001, 32'h101, 32'h5555_5555, 0, 0, 0);
      check("illegal_no_req", cap_addr, 32'hFFFF_FFFF);
      check("illegal_rdata_kept", rdata, 32'h0000_80FF);

      // Ack tied high, back-to-back requests.
      done_before = n_done;
      run_req(1, 0, 3'b010, 32'h300, 0, 0, 32'hCAFE_F00D, 1);
      run_req(0, 1, 3'b010, 32'h304, 32'h0BAD_F00D, 0, 0, 1);
      run_req(1, 0, 3'b100, 32'h306, 0, 0, 32'h00AB_0000, 1);
      run_req(0, 0, 3'b010, 32'h308, 0, 0, 0, 1);
      check("tied_done_count", n_done - done_before, 4);
      mem_ack = 0;

      // Reset in the middle of a request.
      chk_en = 0;
      ls = 1; mem_read = 1; mem_write = 0; funct3 = 3'b010; addr = 32'h400; wdata = 0;
      mem_ack = 0;
      @(posedge clk); #1;
      ls = 0;
      @(posedge clk); #3;
      check("pre_rst_req", mem_req, 1);
      rst = 1;
      #1;
      check("async_rst_req", mem_req, 0);
      check("async_rst_rdata", rdata, 0);
      check("async_rst_addr", mem_addr, 0);
      check("async_rst_be", mem_be, 0);
      check("async_rst_done", done, 0);
      @(posedge clk); #1;
      rst = 0;
      clear_exp(); exp_rdata = 0;
      @(posedge clk); #1;
      chk_en = 1;
      run_req(1, 0, 3'b010, 32'h500, 0, 2, 32'h1357_9BDF, 0);
      check("post_rst_lw", rdata, 32'h1357_9BDF);

      // Randomized traffic.
      for (int n = 0; n < 300; n++) begin
         op = $urandom_range(0, 9);
         r  = (op == 0) || (op >= 2 && op <= 5);
         w  = (op == 0) || (op >= 6);
         f  = 3'($urandom_range(0, 7));
         a  = $urandom;
         if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
         run_req(r, w, f, a, $urandom, $urandom_range(0, 4), $urandom, 0);
      end

      chk_en = 0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
